// File: rtl/adc_interleave_sched.sv
// Round-robin scheduler for a 16-way interleaved ADC: issues channel selects
// to a registered 16:1 mux, tags the returning sample and paces issues by period.
module adc_interleave_sched #(
  parameter int NCH   = 16,
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic             start,
  input  logic             stop,
  input  logic [NCH-1:0]   ch_enable,
  input  logic [PER_W-1:0] period,
  input  logic             out_ready,
  output logic [3:0]       x_adc_select,
  output logic             sel_valid,
  output logic             x_adc_valid,
  output logic [3:0]       x_adc_ch,
  output logic             busy,
  output logic             frame_done,
  output logic             cfg_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WAIT} state_t;

  localparam logic [PER_W-1:0] TWO = PER_W'(2);

  state_t           state_q, state_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [3:0]       sel_q, sel_d;
  logic [3:0]       ch_q, ch_d;
  logic             stop_pend_q, stop_pend_d;
  logic             sel_valid_q, sel_valid_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic [PER_W-1:0] gap_load;
  logic [4:0]       adv;

  function automatic logic [3:0] lowest_ch(input logic [NCH-1:0] m);
    lowest_ch = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) lowest_ch = 4'(i);
  endfunction

  // Returns {wrapped, channel}: first enabled channel above p, else wrap to the lowest.
  function automatic logic [4:0] next_ch(input logic [NCH-1:0] m, input logic [3:0] p);
    logic found;
    found   = 1'b0;
    next_ch = {1'b1, lowest_ch(m)};
    for (int i = 0; i < NCH; i++)
      if (!found && m[i] && (i > int'(p))) begin
        next_ch = {1'b0, 4'(i)};
        found   = 1'b1;
      end
  endfunction

  assign gap_load = ((period_q < TWO) ? TWO : period_q) - TWO;
  assign adv      = next_ch(mask_q, ptr_q);

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    period_d     = period_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    ch_d         = ch_q;
    stop_pend_d  = stop_pend_q;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (|ch_enable) begin
            mask_d      = ch_enable;
            period_d    = period;
            ptr_d       = lowest_ch(ch_enable);
            sel_d       = lowest_ch(ch_enable);
            stop_pend_d = 1'b0;
            state_d     = ISSUE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        ch_d    = ptr_q;
        state_d = CAPTURE;
        if (stop) stop_pend_d = 1'b1;
      end
      CAPTURE: begin
        if (stop) stop_pend_d = 1'b1;
        // A pending stop consumes the handshake instead of advancing the pointer.
        if (out_ready) begin
          if (stop || stop_pend_q) begin
            stop_pend_d = 1'b0;
            state_d     = IDLE;
          end else begin
            ptr_d        = adv[3:0];
            frame_done_d = adv[4];
            if (gap_load == '0) begin
              sel_d   = adv[3:0];
              state_d = ISSUE;
            end else begin
              cnt_d   = gap_load;
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (stop) begin
          cnt_d       = '0;
          stop_pend_d = 1'b0;
          state_d     = IDLE;
        end else if (cnt_q <= PER_W'(1)) begin
          cnt_d   = '0;
          sel_d   = ptr_q;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q - PER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    sel_valid_d = (state_d == ISSUE);
    x_valid_d   = (state_d == CAPTURE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      period_q     <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      sel_q        <= '0;
      ch_q         <= '0;
      stop_pend_q  <= 1'b0;
      sel_valid_q  <= 1'b0;
      x_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      ch_q         <= ch_d;
      stop_pend_q  <= stop_pend_d;
      sel_valid_q  <= sel_valid_d;
      x_valid_q    <= x_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign x_adc_select = sel_q;
  assign sel_valid    = sel_valid_q;
  assign x_adc_valid  = x_valid_q;
  assign x_adc_ch     = ch_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_adc_interleave_sched.sv
// Directed bench for adc_interleave_sched: per-cycle traces are recorded and
// compared against hand-derived issue/capture timing.
module tb_adc_interleave_sched;

  logic        clk = 1'b0;
  logic        GlobalReset;
  logic        start, stop, out_ready;
  logic [15:0] ch_enable;
  logic [7:0]  period;
  logic [3:0]  x_adc_select, x_adc_ch;
  logic        sel_valid, x_adc_valid, busy, frame_done, cfg_err;

  int total = 0;
  int bad   = 0;

  logic [3:0] selA [64];
  logic [3:0] chA  [64];
  logic       svA  [64];
  logic       vA   [64];
  logic       fdA  [64];
  logic       busyA[64];
  logic       cfgA [64];

  adc_interleave_sched #(.NCH(16), .PER_W(8)) dut (
    .clk(clk), .GlobalReset(GlobalReset), .start(start), .stop(stop),
    .ch_enable(ch_enable), .period(period), .out_ready(out_ready),
    .x_adc_select(x_adc_select), .sel_valid(sel_valid), .x_adc_valid(x_adc_valid),
    .x_adc_ch(x_adc_ch), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    GlobalReset = 1'b0;
    tick();
    tick();
    GlobalReset = 1'b1;
  endtask

  task automatic applyStimulus(input logic [15:0] mask, input logic [7:0] per);
    ch_enable = mask;
    period    = per;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Cycle 0 is the first cycle after the start edge; out_ready drops over
  // [rdyLo, rdyHi] and stop pulses in cycle stopAt.
  task automatic runCycles(input int n, input int rdyLo, input int rdyHi, input int stopAt);
    for (int c = 0; c < n; c++) begin
      selA[c] = x_adc_select; chA[c] = x_adc_ch; svA[c] = sel_valid;
      vA[c] = x_adc_valid; fdA[c] = frame_done; busyA[c] = busy; cfgA[c] = cfg_err;
      out_ready = !(c >= rdyLo && c <= rdyHi);
      stop      = (c == stopAt);
      tick();
    end
    out_ready = 1'b1;
    stop      = 1'b0;
  endtask

  function automatic int countOnes(input logic arr[64], input int lo, input int hi);
    int s = 0;
    for (int c = lo; c <= hi; c++) s += int'(arr[c]);
    return s;
  endfunction

  initial begin
    start = 0; stop = 0; out_ready = 1; ch_enable = '0; period = '0;
    doReset();
    checkOutput("rst_sel", x_adc_select, 0);
    checkOutput("rst_ch", x_adc_ch, 0);
    checkOutput("rst_sv", sel_valid, 0);
    checkOutput("rst_v", x_adc_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_fd", frame_done, 0);
    checkOutput("rst_cfg", cfg_err, 0);

    // Full mask, period 2: back-to-back sweep 0..15,0
    applyStimulus(16'hFFFF, 8'd2);
    runCycles(34, -1, -1, -1);
    for (int k = 0; k < 17; k++) begin
      checkOutput($sformatf("s1_sel%0d", k), selA[2*k], k % 16);
      checkOutput($sformatf("s1_sv%0d", k), svA[2*k], 1);
      if (k < 16) checkOutput($sformatf("s1_ch%0d", k), chA[2*k+1], k);
    end
    checkOutput("s1_sv_gap", svA[1], 0);
    checkOutput("s1_fd_cnt", countOnes(fdA, 0, 33), 1);
    checkOutput("s1_fd_at32", fdA[32], 1);

    // Two channels at 5-cycle spacing
    doReset();
    applyStimulus(16'h8001, 8'd5);
    runCycles(20, -1, -1, -1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("s2_sel%0d", k), selA[5*k], (k % 2) ? 15 : 0);
      checkOutput($sformatf("s2_sv%0d", k), svA[5*k], 1);
    end
    checkOutput("s2_sv_wait", svA[3], 0);
    checkOutput("s2_hold3", selA[3], 0);
    checkOutput("s2_hold8", selA[8], 15);
    checkOutput("s2_fd7", fdA[7], 1);
    checkOutput("s2_fd17", fdA[17], 1);
    checkOutput("s2_fd_cnt", countOnes(fdA, 0, 19), 2);

    // Backpressure on ch5
    doReset();
    applyStimulus(16'hFFFF, 8'd2);
    runCycles(17, 11, 13, -1);
    for (int c = 11; c <= 14; c++) begin
      checkOutput($sformatf("s3_v%0d", c), vA[c], 1);
      checkOutput($sformatf("s3_ch%0d", c), chA[c], 5);
      checkOutput($sformatf("s3_sel%0d", c), selA[c], 5);
    end
    checkOutput("s3_v15", vA[15], 0);
    checkOutput("s3_sv15", svA[15], 1);
    checkOutput("s3_sel15", selA[15], 6);

    // Stop during WAIT
    doReset();
    applyStimulus(16'hFFFF, 8'd4);
    runCycles(8, -1, -1, 2);
    checkOutput("s4_busy2", busyA[2], 1);
    checkOutput("s4_busy3", busyA[3], 0);
    checkOutput("s4_sv_after", countOnes(svA, 3, 7), 0);

    // Stop during stalled CAPTURE
    doReset();
    applyStimulus(16'hFFFF, 8'd2);
    runCycles(10, 1, 3, 2);
    checkOutput("s5_v4", vA[4], 1);
    checkOutput("s5_ch4", chA[4], 0);
    checkOutput("s5_v5", vA[5], 0);
    checkOutput("s5_busy5", busyA[5], 0);
    checkOutput("s5_sv_after", countOnes(svA, 5, 9), 0);
    checkOutput("s5_fd", countOnes(fdA, 0, 9), 0);

    // Zero mask rejected
    doReset();
    applyStimulus(16'h0000, 8'd2);
    runCycles(3, -1, -1, -1);
    checkOutput("s6_cfg0", cfgA[0], 1);
    checkOutput("s6_cfg1", cfgA[1], 0);
    checkOutput("s6_busy0", busyA[0], 0);
    checkOutput("s6_busy1", busyA[1], 0);

    // period 0 behaves as 2
    doReset();
    applyStimulus(16'h0003, 8'd0);
    runCycles(6, -1, -1, -1);
    checkOutput("s7_sv1", svA[1], 0);
    checkOutput("s7_sv2", svA[2], 1);
    checkOutput("s7_sel2", selA[2], 1);
    checkOutput("s7_sv4", svA[4], 1);
    checkOutput("s7_sel4", selA[4], 0);
    checkOutput("s7_fd4", fdA[4], 1);

    // period 1 behaves as 2; period/start changes while busy are ignored
    doReset();
    applyStimulus(16'h0003, 8'd1);
    period = 8'd9;
    ch_enable = 16'h0100;
    start = 1'b1;
    runCycles(6, -1, -1, -1);
    start = 1'b0;
    checkOutput("s8_sv2", svA[2], 1);
    checkOutput("s8_sel2", selA[2], 1);
    checkOutput("s8_sv4", svA[4], 1);
    checkOutput("s8_sel4", selA[4], 0);

    // Reset mid-WAIT
    doReset();
    applyStimulus(16'h0030, 8'd6);
    runCycles(3, -1, -1, -1);
    checkOutput("s9_pre_sel", x_adc_select, 4);
    checkOutput("s9_pre_busy", busy, 1);
    GlobalReset = 1'b0;
    tick();
    checkOutput("s9_sel", x_adc_select, 0);
    checkOutput("s9_busy", busy, 0);
    checkOutput("s9_sv", sel_valid, 0);
    checkOutput("s9_v", x_adc_valid, 0);
    checkOutput("s9_fd", frame_done, 0);
    GlobalReset = 1'b1;
    applyStimulus(16'h0030, 8'd2);
    checkOutput("s9_re_sel", x_adc_select, 4);
    checkOutput("s9_re_sv", sel_valid, 1);

    // Reset mid-CAPTURE
    out_ready = 1'b0;
    tick();
    checkOutput("s10_pre_v", x_adc_valid, 1);
    checkOutput("s10_pre_ch", x_adc_ch, 4);
    GlobalReset = 1'b0;
    tick();
    checkOutput("s10_v", x_adc_valid, 0);
    checkOutput("s10_ch", x_adc_ch, 0);
    checkOutput("s10_busy", busy, 0);
    GlobalReset = 1'b1;
    out_ready = 1'b1;
    applyStimulus(16'h0030, 8'd2);
    checkOutput("s10_re_sel", x_adc_select, 4);
    checkOutput("s10_re_sv", sel_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
